// File: rtl/mac_array.sv
// rtl/mac_array.sv - multi-lane signed fixed-point MAC array with saturating accumulate and quantize
module mac_array #(
  parameter int COUNT      = 128,
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_BITS  = 8
) (
  input  logic                             clk,
  input  logic                             rst_b,
  input  logic                             start,
  input  logic                             valid_in,
  input  logic                             last_in,
  input  logic                             relu_en,
  input  logic [DATA_WIDTH*COUNT-1:0]      mult_inp_1,
  input  logic [DATA_WIDTH*COUNT-1:0]      mult_inp_2,
  input  logic [2*DATA_WIDTH*COUNT-1:0]    add_inp,
  output logic                             busy,
  output logic [2*DATA_WIDTH*COUNT-1:0]    acc_out,
  output logic [DATA_WIDTH*COUNT-1:0]      layer_output,
  output logic                             out_valid,
  output logic [15:0]                      term_cnt
);

  localparam int DW = DATA_WIDTH;
  localparam int AW = 2 * DATA_WIDTH;
  localparam logic [AW:0] RND_HALF = (AW+1)'(1) << (FRAC_BITS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_DRAIN, S_QUANT} state_t;

  state_t      r_state;
  state_t      w_next;
  logic        r_relu;
  logic        r_p_valid;
  logic        r_busy;
  logic        r_out_valid;
  logic [15:0] r_term_cnt;
  logic        w_load;
  logic        w_take;
  logic        w_quant;

  // A term presented alongside start is the first term of the new dot product.
  always_comb begin
    w_load  = 1'b0;
    w_take  = 1'b0;
    w_quant = 1'b0;
    w_next  = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_load = 1'b1;
          w_take = valid_in;
          w_next = (valid_in && last_in) ? S_DRAIN : S_ACCUM;
        end
      end
      S_ACCUM: begin
        w_take = valid_in;
        if (valid_in && last_in) w_next = S_DRAIN;
      end
      S_DRAIN: w_next = S_QUANT;
      S_QUANT: begin
        w_quant = 1'b1;
        w_next  = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_b) begin
      r_state     <= S_IDLE;
      r_relu      <= 1'b0;
      r_p_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
      r_term_cnt  <= 16'd0;
    end else begin
      r_state     <= w_next;
      r_p_valid   <= w_take;
      r_out_valid <= w_quant;
      if (w_load) begin
        r_relu     <= relu_en;
        r_busy     <= 1'b1;
        r_term_cnt <= w_take ? 16'd1 : 16'd0;
      end else begin
        if (w_take && (r_term_cnt != 16'hFFFF)) r_term_cnt <= r_term_cnt + 16'd1;
        if (w_quant) r_busy <= 1'b0;
      end
    end
  end

  assign busy      = r_busy;
  assign out_valid = r_out_valid;
  assign term_cnt  = r_term_cnt;

  for (genvar g = 0; g < COUNT; g++) begin : g_lane
    logic [DW-1:0]        w_a;
    logic [DW-1:0]        w_b;
    logic signed [AW-1:0] w_prod;
    logic signed [AW:0]   w_sum;
    logic [AW-1:0]        w_sum_sat;
    logic [AW:0]          w_rnd;
    logic signed [AW-1:0] w_rnd_sat;
    logic signed [AW-1:0] w_shift;
    logic [DW-1:0]        w_q;
    logic [AW-1:0]        r_p;
    logic [AW-1:0]        r_acc;
    logic [AW-1:0]        r_acc_out;
    logic [DW-1:0]        r_layer;

    assign w_a    = mult_inp_1[g*DW +: DW];
    assign w_b    = mult_inp_2[g*DW +: DW];
    assign w_prod = $signed({{DW{w_a[DW-1]}}, w_a}) * $signed({{DW{w_b[DW-1]}}, w_b});
    assign w_sum  = $signed({r_acc[AW-1], r_acc}) + $signed({r_p[AW-1], r_p});

    // Overflow shows up as disagreement between the guard bit and the sign bit.
    always_comb begin
      w_sum_sat = w_sum[AW-1:0];
      if (w_sum[AW] != w_sum[AW-1])
        w_sum_sat = w_sum[AW] ? {1'b1, {(AW-1){1'b0}}} : {1'b0, {(AW-1){1'b1}}};
    end

    assign w_rnd     = {r_acc[AW-1], r_acc} + RND_HALF;
    assign w_rnd_sat = (w_rnd[AW] != w_rnd[AW-1]) ? {1'b0, {(AW-1){1'b1}}} : w_rnd[AW-1:0];
    assign w_shift   = w_rnd_sat >>> FRAC_BITS;

    always_comb begin
      w_q = w_shift[DW-1:0];
      if (w_shift[AW-1:DW-1] != {(AW-DW+1){w_shift[DW-1]}})
        w_q = w_shift[AW-1] ? {1'b1, {(DW-1){1'b0}}} : {1'b0, {(DW-1){1'b1}}};
      if (r_relu && w_q[DW-1]) w_q = '0;
    end

    always_ff @(posedge clk) begin
      if (rst_b) begin
        r_p       <= '0;
        r_acc     <= '0;
        r_acc_out <= '0;
        r_layer   <= '0;
      end else begin
        if (w_take) r_p <= w_prod;
        if (w_load) r_acc <= add_inp[g*AW +: AW];
        else if (r_p_valid) r_acc <= w_sum_sat;
        if (w_quant) begin
          r_acc_out <= r_acc;
          r_layer   <= w_q;
        end
      end
    end

    assign acc_out[g*AW +: AW]      = r_acc_out;
    assign layer_output[g*DW +: DW] = r_layer;
  end

endmodule

// File: tb/tb_mac_array.sv
// tb/tb_mac_array.sv - directed self-checking bench for mac_array with two lanes
module tb_mac_array;
  localparam int COUNT = 2;
  localparam int DW    = 16;
  localparam int FB    = 8;

  logic              clk = 1'b0;
  logic              rst_b = 1'b1;
  logic              start = 1'b0;
  logic              valid_in = 1'b0;
  logic              last_in = 1'b0;
  logic              relu_en = 1'b0;
  logic [DW*COUNT-1:0]   mult_inp_1 = '0;
  logic [DW*COUNT-1:0]   mult_inp_2 = '0;
  logic [2*DW*COUNT-1:0] add_inp = '0;
  logic              busy;
  logic [2*DW*COUNT-1:0] acc_out;
  logic [DW*COUNT-1:0]   layer_output;
  logic              out_valid;
  logic [15:0]       term_cnt;

  int n_pass  = 0;
  int n_total = 0;

  mac_array #(.COUNT(COUNT), .DATA_WIDTH(DW), .FRAC_BITS(FB)) dut (
    .clk(clk), .rst_b(rst_b), .start(start), .valid_in(valid_in), .last_in(last_in),
    .relu_en(relu_en), .mult_inp_1(mult_inp_1), .mult_inp_2(mult_inp_2), .add_inp(add_inp),
    .busy(busy), .acc_out(acc_out), .layer_output(layer_output), .out_valid(out_valid),
    .term_cnt(term_cnt)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic chk_lanes(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                           input logic [15:0] q0, input logic [15:0] q1);
    chk({tag, "_acc0"}, 64'(acc_out[31:0]), 64'(a0));
    chk({tag, "_acc1"}, 64'(acc_out[63:32]), 64'(a1));
    chk({tag, "_q0"}, 64'(layer_output[15:0]), 64'(q0));
    chk({tag, "_q1"}, 64'(layer_output[31:16]), 64'(q1));
  endtask

  // Start cycle, then n identical terms with last_in on the final one, then the 3-cycle result latency.
  task automatic layer(input string tag, input logic [31:0] b0, input logic [31:0] b1, input logic relu,
                       input int n, input logic [15:0] a0, input logic [15:0] x0,
                       input logic [15:0] a1, input logic [15:0] x1);
    start = 1'b1; add_inp = {b1, b0}; relu_en = relu; valid_in = 1'b0; last_in = 1'b0;
    tick();
    start = 1'b0; relu_en = 1'b0;
    for (int i = 0; i < n; i++) begin
      valid_in = 1'b1; last_in = (i == n - 1);
      mult_inp_1 = {a1, a0}; mult_inp_2 = {x1, x0};
      tick();
    end
    valid_in = 1'b0; last_in = 1'b0; mult_inp_1 = '0; mult_inp_2 = '0;
    tick();
    chk({tag, "_ov_early"}, 64'(out_valid), 64'd0);
    tick();
    chk({tag, "_ov"}, 64'(out_valid), 64'd1);
    chk({tag, "_busy_done"}, 64'(busy), 64'd0);
  endtask

  initial begin
    tick(); tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_ov", 64'(out_valid), 64'd0);
    chk("rst_tc", 64'(term_cnt), 64'd0);
    chk_lanes("rst", 32'h0, 32'h0, 16'h0, 16'h0);
    rst_b = 1'b0;
    tick();

    // Single term together with start: 0.5 + 2.0*1.5 = 3.5
    start = 1'b1; add_inp = {32'h0, 32'h0000_8000}; valid_in = 1'b1; last_in = 1'b1;
    mult_inp_1 = {16'h0, 16'h0200}; mult_inp_2 = {16'h0, 16'h0180};
    tick();
    start = 1'b0; valid_in = 1'b0; last_in = 1'b0; mult_inp_1 = '0; mult_inp_2 = '0;
    chk("t1_busy", 64'(busy), 64'd1);
    chk("t1_ov_n1", 64'(out_valid), 64'd0);
    tick();
    chk("t1_ov_n2", 64'(out_valid), 64'd0);
    tick();
    chk("t1_ov_n3", 64'(out_valid), 64'd1);
    chk("t1_tc", 64'(term_cnt), 64'd1);
    chk_lanes("t1", 32'h0003_8000, 32'h0, 16'h0380, 16'h0);
    tick();
    chk("t1_ov_pulse", 64'(out_valid), 64'd0);
    chk_lanes("t1_hold", 32'h0003_8000, 32'h0, 16'h0380, 16'h0);

    layer("sat", 32'h0, 32'h0, 1'b0, 4, 16'h7FFF, 16'h7FFF, 16'h8000, 16'h7FFF);
    chk("sat_tc", 64'(term_cnt), 64'd4);
    chk_lanes("sat", 32'h7FFF_FFFF, 32'h8000_0000, 16'h7FFF, 16'h8000);

    layer("rnd_a", 32'h0, 32'h0, 1'b0, 1, 16'h0001, 16'h0080, 16'h0001, 16'h007F);
    chk_lanes("rnd_a", 32'h0000_0080, 32'h0000_007F, 16'h0001, 16'h0000);
    layer("rnd_b", 32'h0, 32'h0, 1'b0, 1, 16'h0001, 16'hFF80, 16'h0000, 16'h0000);
    chk_lanes("rnd_b", 32'hFFFF_FF80, 32'h0, 16'h0000, 16'h0000);

    layer("relu_on", 32'h0, 32'h0, 1'b1, 1, 16'h0200, 16'hFF00, 16'h0100, 16'h0300);
    chk_lanes("relu_on", 32'hFFFE_0000, 32'h0003_0000, 16'h0000, 16'h0300);
    layer("relu_off", 32'h0, 32'h0, 1'b0, 1, 16'h0200, 16'hFF00, 16'h0100, 16'h0300);
    chk_lanes("relu_off", 32'hFFFE_0000, 32'h0003_0000, 16'hFE00, 16'h0300);

    // Back-to-back: start in the out_valid cycle, a second start during ACCUM must be ignored.
    start = 1'b1; add_inp = {32'h0, 32'h0001_0000};
    tick();
    chk("b2b_busy", 64'(busy), 64'd1);
    chk("b2b_hold_q0", 64'(layer_output[15:0]), 64'hFE00);
    start = 1'b1; add_inp = {32'h7FFF_0000, 32'h7FFF_0000};
    valid_in = 1'b1; mult_inp_1 = {16'h0, 16'h0100}; mult_inp_2 = {16'h0, 16'h0200};
    tick();
    start = 1'b0; last_in = 1'b1; mult_inp_2 = {16'h0, 16'h0100};
    tick();
    valid_in = 1'b0; last_in = 1'b0; mult_inp_1 = '0; mult_inp_2 = '0;
    tick();
    chk("b2b_hold_n2", 64'(layer_output[15:0]), 64'hFE00);
    tick();
    chk("b2b_ov", 64'(out_valid), 64'd1);
    chk("b2b_tc", 64'(term_cnt), 64'd2);
    chk_lanes("b2b", 32'h0004_0000, 32'h0, 16'h0400, 16'h0);

    // Reset in the middle of an accumulation after three terms.
    start = 1'b1; add_inp = {32'h0001_0000, 32'h0001_0000};
    tick();
    start = 1'b0; valid_in = 1'b1; mult_inp_1 = {16'h0100, 16'h0100}; mult_inp_2 = {16'h0100, 16'h0100};
    tick(); tick(); tick();
    chk("mid_tc", 64'(term_cnt), 64'd3);
    valid_in = 1'b0; rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    chk("mr_busy", 64'(busy), 64'd0);
    chk("mr_ov", 64'(out_valid), 64'd0);
    chk("mr_tc", 64'(term_cnt), 64'd0);
    chk_lanes("mr", 32'h0, 32'h0, 16'h0, 16'h0);
    valid_in = 1'b1; last_in = 1'b1;
    tick();
    valid_in = 1'b0; last_in = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("mr_no_ov", 64'(out_valid), 64'd0);
    end
    chk("mr_tc_idle", 64'(term_cnt), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
